// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
//   Sequences one operand-streaming job into a systolic array through its
//   skew buffer. A job has four steps: clear the accumulators, read k operand
//   vectors from the buffer (honouring stall), push 2*N_SIZE-1 zero beats so
//   the skewed data drains out of the array, and pulse done.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   launch request, only looked at in IDLE
//   abort     in   cancel the running job, return to IDLE
//   cfg_base  in   first operand address (latched at launch)
//   cfg_k     in   number of operand vectors (latched at launch)
//   stall     in   operand buffer not ready, holds read issue in FEED
//   rd_en     out  operand buffer read strobe
//   rd_addr   out  operand buffer read address
//   sa_valid  out  skew buffer valid_in (one cycle after the issue slot)
//   sa_zero   out  skew buffer zero select (flush beat)
//   sa_clear  out  one-cycle accumulator clear
//   busy      out  job in progress
//   done      out  one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | accumulator clear pulse, choose FEED or DONE
// FEED  | issuing operand reads, one per unstalled cycle
// DRAIN | issuing zero beats to flush the skew pipeline
// DONE  | completion pulse, aligned with the last zero beat on sa_valid

module systolic_feed_ctrl #(
  parameter int N_SIZE = 4,
  parameter int ADDR_W = 8,
  parameter int K_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [K_W-1:0]    cfg_k,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sa_valid,
  output logic              sa_zero,
  output logic              sa_clear,
  output logic              busy,
  output logic              done
);

  localparam int DRAIN_LEN = 2 * N_SIZE - 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [K_W-1:0]    issued_q, issued_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              valid_q, zero_q;
  logic              issue, issue_zero;
  logic              kill;

  // abort only acts on a running job; in IDLE it is a don't-care
  assign kill = abort && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    k_d        = k_q;
    issued_d   = issued_q;
    drain_d    = drain_q;
    rd_en      = 1'b0;
    rd_addr    = '0;
    sa_clear   = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    issue_zero = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CLEAR;
          base_d   = cfg_base;
          k_d      = cfg_k;
          issued_d = '0;
        end
      end
      CLEAR: begin
        sa_clear = 1'b1;
        issued_d = '0;
        state_d  = (k_q == '0) ? DONE : FEED;
      end
      FEED: begin
        // address wraps naturally at 2^ADDR_W
        rd_addr = base_q + ADDR_W'(issued_q);
        rd_en   = !stall;
        issue   = !stall;
        if (!stall) begin
          if (issued_q == k_q - K_W'(1)) begin
            state_d = DRAIN;
            drain_d = DRAIN_LAST;
          end else begin
            issued_d = issued_q + K_W'(1);
          end
        end
      end
      DRAIN: begin
        issue      = 1'b1;
        issue_zero = 1'b1;
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - DW'(1);
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill) begin
      state_d    = IDLE;
      rd_en      = 1'b0;
      issue      = 1'b0;
      issue_zero = 1'b0;
      done       = 1'b0;
    end
  end

  // The registered beat is also masked in the abort cycle itself so the
  // array never sees a beat belonging to a cancelled job.
  assign sa_valid = valid_q && !kill;
  assign sa_zero  = zero_q && !kill;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      k_q      <= '0;
      issued_q <= '0;
      drain_q  <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      k_q      <= k_d;
      issued_q <= issued_d;
      drain_q  <= drain_d;
      valid_q  <= issue;
      zero_q   <= issue_zero;
    end
  end

endmodule
